// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer beside writeback: picks one event per
// instruction boundary, drains memory traffic, pulses the CSR commit, then redirects fetch.
module trap_sequencer #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic            wb_exc,
    input  logic [3:0]      wb_exc_code,
    input  logic            wb_mret,
    input  logic            trint,
    input  logic            swint,
    input  logic            exint,
    input  logic            mstatus_mie,
    input  logic [2:0]      mie_mask,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            mem_busy,
    output logic            wb_kill,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            csr_trap_valid,
    output logic            csr_trap_is_int,
    output logic [3:0]      csr_trap_code,
    output logic [XLEN-1:0] csr_trap_epc,
    output logic            csr_mret_valid,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StDrain, StCommit, StRedirect} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_exint_meta;
    logic            r_exint_sync;
    logic            r_is_mret;
    logic            r_is_int;
    logic [3:0]      r_code;
    logic [XLEN-1:0] r_epc;

    logic [2:0]      w_pend;
    logic            w_int_take;
    logic [3:0]      w_int_code;
    logic            w_accept;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exint_meta <= 1'b0;
            r_exint_sync <= 1'b0;
        end else begin
            r_exint_meta <= exint;
            r_exint_sync <= r_exint_meta;
        end
    end

    always_comb begin
        w_pend     = {r_exint_sync, swint, trint} & mie_mask;
        w_int_take = mstatus_mie & (|w_pend);
        if (w_pend[2]) begin
            w_int_code = 4'd11;
        end else if (w_pend[1]) begin
            w_int_code = 4'd3;
        end else begin
            w_int_code = 4'd7;
        end
        w_accept = (r_state == StIdle) & wb_valid & (wb_exc | wb_mret | w_int_take);
    end

    // Priority: exception > mret > interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_mret <= 1'b0;
            r_is_int  <= 1'b0;
            r_code    <= 4'd0;
            r_epc     <= '0;
        end else if (w_accept) begin
            r_is_mret <= ~wb_exc & wb_mret;
            r_is_int  <= ~wb_exc & ~wb_mret;
            r_code    <= wb_exc ? wb_exc_code : (wb_mret ? 4'd0 : w_int_code);
            r_epc     <= wb_pc;
        end
    end

    // Target is read during REDIRECT so a CSR write from COMMIT is already visible.
    always_comb begin
        w_base = {mtvec[XLEN-1:2], 2'b00};
        if (r_is_mret) begin
            w_target = mepc;
        end else if (mtvec[1:0] == 2'b01 && r_is_int) begin
            w_target = w_base + {{(XLEN-6){1'b0}}, r_code, 2'b00};
        end else begin
            w_target = w_base;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        wb_kill        = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_trap_valid = 1'b0;
        csr_mret_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                wb_kill = w_accept & (wb_exc | ~wb_mret);
                if (w_accept) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                stall = 1'b1;
                if (!mem_busy) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: begin
                stall          = 1'b1;
                csr_trap_valid = ~r_is_mret;
                csr_mret_valid = r_is_mret;
                w_state_next   = StRedirect;
            end
            StRedirect: begin
                stall          = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = w_target;
                w_state_next   = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign csr_trap_is_int = r_is_int;
    assign csr_trap_code   = r_code;
    assign csr_trap_epc    = r_epc;
    assign busy            = (r_state != StIdle);

endmodule
